tune_ctrl: RTL

Front-panel tuning controller for the receiver. Converts four raw, bouncing push-buttons into a saturating 40-bit NCO phase increment with fine and coarse steps and optional hold-to-repeat. It sits directly upstream of `nco`, replacing ad-hoc button logic at the top level. It runs on the 100 MHz DSP clock.

---
 rtl/tune_pkg.sv | 34 +++
 rtl/tune_ctrl_if.sv | 22 ++
 rtl/tune_btn.sv | 113 +++++++++++
 rtl/tune_ctrl.sv | 57 +++++
 4 files changed

// File: rtl/tune_pkg.sv
// Shared constants, button FSM states and the saturating step helper
// used by the front-panel tuning controller.
package tune_pkg;

    localparam int PHASE_W = 40;
    localparam logic [PHASE_W-1:0] FINE_STEP   = 40'h110c6f7;
    localparam logic [PHASE_W-1:0] COARSE_STEP = 40'h1346dc5d;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } btn_state_t;

    // The sum/difference is formed one bit wider so carry and borrow are visible.
    function automatic logic [PHASE_W-1:0] sat_step(
        input logic [PHASE_W-1:0] cur,
        input logic [PHASE_W-1:0] step,
        input logic [PHASE_W-1:0] lo,
        input logic [PHASE_W-1:0] hi,
        input logic               sub
    );
        logic [PHASE_W:0] res;
        if (sub) begin
            res = {1'b0, cur} - {1'b0, step};
            if (res[PHASE_W] || (res[PHASE_W-1:0] < lo)) return lo;
        end else begin
            res = {1'b0, cur} + {1'b0, step};
            if (res > {1'b0, hi}) return hi;
        end
        return res[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/tune_ctrl_if.sv
// Button inputs and tuning outputs of the controller; the panel side is the
// master, the controller the slave.
interface tune_ctrl_if;
    import tune_pkg::*;

    logic               btn_coarse_up;
    logic               btn_coarse_dn;
    logic               btn_fine_up;
    logic               btn_fine_dn;
    logic [PHASE_W-1:0] phase_inc;
    logic               step_tick;

    modport master (
        output btn_coarse_up, btn_coarse_dn, btn_fine_up, btn_fine_dn,
        input  phase_inc, step_tick
    );

    modport slave (
        input  btn_coarse_up, btn_coarse_dn, btn_fine_up, btn_fine_dn,
        output phase_inc, step_tick
    );
endinterface

// File: rtl/tune_btn.sv
// One push-button: 2-flop synchroniser, debouncer and press/repeat FSM emitting ev.
// Hold-to-repeat exists only when TUNE_CTRL_AUTOREPEAT_EN is defined.
module tune_btn
    import tune_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic ev
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic [DB_W-1:0] db_cnt;
    btn_state_t      state;
    btn_state_t      state_next;
    logic            ev_next;

    // The count only advances while the synchronised level disagrees with the accepted one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level  <= sync_b;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef TUNE_CTRL_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_next;

    always_ff @(posedge CLK) begin
        if (RST) rpt_cnt <= '0;
        else     rpt_cnt <= rpt_cnt_next;
    end
`else
    logic [31:0] unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_RATE;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ev    <= 1'b0;
        end else begin
            state <= state_next;
            ev    <= ev_next;
        end
    end

    always_comb begin
        state_next = state;
        ev_next    = 1'b0;
`ifdef TUNE_CTRL_AUTOREPEAT_EN
        rpt_cnt_next = rpt_cnt + RPT_W'(1);
`endif
        case (state)
            IDLE: begin
`ifdef TUNE_CTRL_AUTOREPEAT_EN
                rpt_cnt_next = '0;
`endif
                if (level) begin
                    state_next = HELD;
                    ev_next    = 1'b1;
                end
            end
`ifdef TUNE_CTRL_AUTOREPEAT_EN
            HELD: begin
                if (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
                    state_next   = REPEAT;
                    ev_next      = 1'b1;
                    rpt_cnt_next = '0;
                end
            end
            REPEAT: begin
                if (rpt_cnt == RPT_W'(REPEAT_RATE - 1)) begin
                    ev_next      = 1'b1;
                    rpt_cnt_next = '0;
                end
            end
`endif
            default: state_next = state;
        endcase
        // A debounced release wins over any pending step.
        if (!level) begin
            state_next = IDLE;
            ev_next    = 1'b0;
        end
    end

endmodule

// File: rtl/tune_ctrl.sv
// Front-panel tuning controller: four debounced buttons drive a saturating
// phase increment for the NCO. Auto-repeat is enabled by TUNE_CTRL_AUTOREPEAT_EN.
module tune_ctrl
    import tune_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned        REPEAT_DELAY    = 50_000_000,
    parameter int unsigned        REPEAT_RATE     = 10_000_000,
    parameter logic [PHASE_W-1:0] INC_RESET       = 40'h2656abde3,
    parameter logic [PHASE_W-1:0] INC_MIN         = 40'h0,
    parameter logic [PHASE_W-1:0] INC_MAX         = 40'h47ae147ae1
) (
    input logic        CLK,
    input logic        RST,
    tune_ctrl_if.slave bus
);

    logic               ev_cu;
    logic               ev_cd;
    logic               ev_fu;
    logic               ev_fd;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_next;
    logic               tick_q;

    tune_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_coarse_up (.CLK(CLK), .RST(RST), .raw(bus.btn_coarse_up), .ev(ev_cu));
    tune_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_coarse_dn (.CLK(CLK), .RST(RST), .raw(bus.btn_coarse_dn), .ev(ev_cd));
    tune_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_fine_up (.CLK(CLK), .RST(RST), .raw(bus.btn_fine_up), .ev(ev_fu));
    tune_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_fine_dn (.CLK(CLK), .RST(RST), .raw(bus.btn_fine_dn), .ev(ev_fd));

    // Fixed priority; losing events in the same cycle are simply dropped.
    always_comb begin
        phase_next = phase_q;
        if (ev_cu)      phase_next = sat_step(phase_q, COARSE_STEP, INC_MIN, INC_MAX, 1'b0);
        else if (ev_cd) phase_next = sat_step(phase_q, COARSE_STEP, INC_MIN, INC_MAX, 1'b1);
        else if (ev_fu) phase_next = sat_step(phase_q, FINE_STEP, INC_MIN, INC_MAX, 1'b0);
        else if (ev_fd) phase_next = sat_step(phase_q, FINE_STEP, INC_MIN, INC_MAX, 1'b1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= INC_RESET;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_next;
            tick_q  <= (phase_next != phase_q);
        end
    end

    assign bus.phase_inc = phase_q;
    assign bus.step_tick = tick_q;

endmodule
